// File: rtl/mul_row_sequencer.sv
// mul_row_sequencer
// Drives a schoolbook multi-word multiply, one row at a time, into an
// accumulating partial-product store. Row i reads word i of operand A against
// words 0..N-1 of operand B. The product stream reaches the store with a
// valid/padding pair that is delay-matched to the operand read and multiplier
// pipe. The sequencer waits for the store's output pass before the next row.
//
// Optional build macro: MUL_SEQ_TIMEOUT_EN
//   Adds parameter TIMEOUT_CYCLES and output timeout_out. When it is defined,
//   ARM and DRAIN give up after TIMEOUT_CYCLES cycles and return to IDLE.
//
// Ports:
//   clk_in          clock
//   rst_in          synchronous reset, active low
//   start_in        begin a multiply (honoured only when idle)
//   store_ready_in  store is ready to accept a row
//   store_valid_in  store output pass in progress
//   busy_out        sequencer not idle
//   done_out        one-cycle pulse after the last row's drain
//   a_addr_out      operand A word address (row index)
//   b_addr_out      operand B word address
//   op_rd_out       read enable for both operand BRAMs
//   mul_valid_out   product valid to the store (op_rd_out delayed PIPE_LATENCY)
//   pad_out         start padding to the store (row delayed PIPE_LATENCY)
//   timeout_out     (MUL_SEQ_TIMEOUT_EN only) one-cycle pulse on a wait timeout
module mul_row_sequencer #(
  parameter int REGISTER_SIZE   = 32,
  parameter int NUM_BITS_STORED = 2048,
  parameter int DESIRED_SIZE    = 2080,
  parameter int PIPE_LATENCY    = 3,
`ifdef MUL_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES  = 4096,
`endif
  localparam int N  = NUM_BITS_STORED / REGISTER_SIZE,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int PW = $clog2(DESIRED_SIZE) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic          store_ready_in,
  input  logic          store_valid_in,
  output logic          busy_out,
  output logic          done_out,
  output logic [AW-1:0] a_addr_out,
  output logic [AW-1:0] b_addr_out,
  output logic          op_rd_out,
  output logic          mul_valid_out,
  output logic [PW-1:0] pad_out
`ifdef MUL_SEQ_TIMEOUT_EN
  ,
  output logic          timeout_out
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int              FW         = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [AW-1:0]   LAST_IDX   = AW'(N - 1);
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(PIPE_LATENCY - 1);

  logic [2:0]    state;
  logic [AW-1:0] row;
  logic [AW-1:0] b_idx;
  logic [FW-1:0] flush_cnt;
  logic          seen;
  logic          tmo_hit;

  logic          vld_p [PIPE_LATENCY];
  logic [PW-1:0] pad_p [PIPE_LATENCY];

  assign busy_out      = (state != S_IDLE);
  assign done_out      = (state == S_DONE);
  assign op_rd_out     = (state == S_ISSUE);
  assign a_addr_out    = row;
  assign b_addr_out    = b_idx;
  assign mul_valid_out = vld_p[PIPE_LATENCY-1];
  assign pad_out       = pad_p[PIPE_LATENCY-1];

  // Row scheduler
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= S_IDLE;
      row       <= '0;
      b_idx     <= '0;
      flush_cnt <= '0;
      seen      <= 1'b0;
    end else if (tmo_hit) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) begin
            row   <= '0;
            seen  <= 1'b0;
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (store_ready_in) begin
            b_idx <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (b_idx == LAST_IDX) begin
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else begin
            b_idx <= b_idx + 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= S_DRAIN;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // The pass is complete only after a high has been seen and valid
          // has dropped again; a high already present on entry counts.
          if (store_valid_in) begin
            seen <= 1'b1;
          end else if (seen) begin
            seen <= 1'b0;
            if (row == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              row   <= row + 1'b1;
              state <= S_ARM;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Delay-match stages p0..p(PIPE_LATENCY-1): operand read + multiplier
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
        pad_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= op_rd_out;
      pad_p[0] <= PW'(row);
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        pad_p[i] <= pad_p[i-1];
      end
    end
  end

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q;
  logic [TW-1:0] wait_cnt;
  logic [TW-1:0] cnt_now;
  logic          in_wait;

  // A state change since last cycle means this is the first cycle of the
  // state, so the count restarts from zero on every entry.
  assign in_wait = (state == S_ARM) || (state == S_DRAIN);
  assign cnt_now = (state != state_q) ? '0 : wait_cnt;
  assign tmo_hit = in_wait && (cnt_now == TMO_LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      wait_cnt    <= '0;
      timeout_out <= 1'b0;
    end else begin
      state_q     <= state;
      wait_cnt    <= in_wait ? cnt_now + 1'b1 : '0;
      timeout_out <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mul_row_sequencer.sv
`timescale 1ns/1ps
module tb_mul_row_sequencer;

  localparam int LAT = 2;
  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int PW  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sready = 1'b0;
  logic svalid = 1'b0;
  logic busy, done, op_rd, mv;
  logic [AW-1:0] a_addr, b_addr;
  logic [PW-1:0] pad;
  logic tmo_sig;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MUL_SEQ_TIMEOUT_EN
  logic tmo;
  assign tmo_sig = tmo;
`else
  assign tmo_sig = 1'b0;
`endif

  mul_row_sequencer #(
    .REGISTER_SIZE(8),
    .NUM_BITS_STORED(32),
    .DESIRED_SIZE(48),
    .PIPE_LATENCY(LAT)
`ifdef MUL_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .start_in(start),
    .store_ready_in(sready),
    .store_valid_in(svalid),
    .busy_out(busy),
    .done_out(done),
    .a_addr_out(a_addr),
    .b_addr_out(b_addr),
    .op_rd_out(op_rd),
    .mul_valid_out(mv),
    .pad_out(pad)
`ifdef MUL_SEQ_TIMEOUT_EN
    , .timeout_out(tmo)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: rows issue in order 0..N-1 as contiguous bursts of N
  // reads with b = 0..N-1; the store sees each read exactly LAT cycles later
  // with the row as padding, unless a reset edge fell inside that window.
  logic          hist_rd  [0:8191];
  logic [AW-1:0] hist_a   [0:8191];
  logic          rst_edge [0:8191];
  int run_pos = 0;
  int rows_issued = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;
  logic [PW-1:0] mv_pad [$];
  logic          exp_mv;
  logic [PW-1:0] exp_pad;
  bit            win_ok;

  always @(posedge clk) begin
    if (cyc < 8192) rst_edge[cyc] = rst_n;
    if (!rst_n) begin
      run_pos = 0;
      rows_issued = 0;
    end
  end

  always @(negedge clk) begin
    if (cyc < 8192) begin
      hist_rd[cyc] = op_rd;
      hist_a[cyc]  = a_addr;
      exp_mv  = 1'b0;
      exp_pad = '0;
      if (cyc >= LAT) begin
        win_ok = 1'b1;
        for (int k = cyc - LAT; k < cyc; k++) if (!rst_edge[k]) win_ok = 1'b0;
        if (win_ok) begin
          exp_mv  = hist_rd[cyc-LAT];
          exp_pad = PW'(hist_a[cyc-LAT]);
        end
      end
      chk("mul_valid", mv, exp_mv);
      chk("pad", pad, exp_pad);
      if (run_pos != 0) chk("op_rd_contig", op_rd, 1);
      if (op_rd) begin
        chk("a_addr", a_addr, rows_issued % N);
        chk("b_addr", b_addr, run_pos);
        chk("busy_in_issue", busy, 1);
        run_pos++;
        if (run_pos == N) begin
          run_pos = 0;
          rows_issued++;
        end
      end else if (rows_issued > 0) begin
        chk("b_addr_hold", b_addr, N - 1);
      end
      if (mv) mv_pad.push_back(pad);
      if (done) done_cnt++;
      if (tmo_sig) tmo_cnt++;
    end
  end

  task automatic wait_for(input int which, input logic val, input int maxc,
                          input string name, output int at);
    logic s;
    bit found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i <= maxc && !found; i++) begin
      case (which)
        0: s = op_rd;
        1: s = mv;
        2: s = done;
        default: s = tmo_sig;
      endcase
      if (s === val) begin
        found = 1'b1;
        at = cyc;
      end else begin
        tick();
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: got no event within %0d cycles, expected level %0d", name, maxc, val);
    end
  endtask

  task automatic store_pass();
    repeat (3) tick();
    svalid = 1'b1;
    repeat (5) tick();
    svalid = 1'b0;
  endtask

  task automatic run_full(input bit bp, input bit inject_start);
    int t, t0, rdc, fall, d0, ready_cyc;
    ready_cyc = 0;
    fall = 0;
    d0 = done_cnt;
    mv_pad.delete();
    sready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int r = 0; r < N; r++) begin
      wait_for(0, 1'b1, 200, "wait_op_rd", rdc);
      if (r == 0) chk("first_issue_latency", rdc - t0, 2);
      if (bp && r == 2) chk("issue_after_ready", rdc - ready_cyc, 1);
      if (inject_start && r == 2) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_for(1, 1'b1, 50, "wait_mv_rise", t);
      chk("mv_latency", t - rdc, LAT);
      wait_for(1, 1'b0, 50, "wait_mv_fall", t);
      chk("mv_burst_len", t - rdc - LAT, N);
      if (bp && r == 1) sready = 1'b0;
      store_pass();
      fall = cyc;
      if (bp && r == 1) begin
        repeat (10) begin
          tick();
          chk("no_issue_in_arm", op_rd, 0);
        end
        sready = 1'b1;
        ready_cyc = cyc;
      end
    end
    wait_for(2, 1'b1, 20, "wait_done", t);
    chk("done_timing", t - fall, 1);
    tick();
    chk("done_one_cycle", done, 0);
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("mv_total", mv_pad.size(), N * N);
    for (int k = 0; k < mv_pad.size(); k++) chk("pad_seq", mv_pad[k], k / N);
  endtask

  task automatic reset_mid_issue();
    int t, d0;
    bit hit;
    hit = 1'b0;
    d0 = done_cnt;
    sready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for(1, 1'b1, 50, "rmi_mv_rise", t);
    wait_for(1, 1'b0, 50, "rmi_mv_fall", t);
    store_pass();
    for (int i = 0; i < 50 && !hit; i++) begin
      if (op_rd === 1'b1 && a_addr === 2'd1 && b_addr === 2'd2) hit = 1'b1;
      else tick();
    end
    chk("rmi_reached_b2", hit, 1);
    chk("rmi_mv_before_reset", mv, 1);
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk("rmi_mv", mv, 0);
    chk("rmi_busy", busy, 0);
    chk("rmi_op_rd", op_rd, 0);
    chk("rmi_pad", pad, 0);
    chk("rmi_a_addr", a_addr, 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (10) begin
      tick();
      chk("rmi_mv_after", mv, 0);
      chk("rmi_busy_after", busy, 0);
    end
    chk("rmi_no_done", done_cnt - d0, 0);
  endtask

`ifdef MUL_SEQ_TIMEOUT_EN
  task automatic timeout_test();
    int t, d, d0;
    d0 = done_cnt;
    sready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for(1, 1'b1, 50, "tmo_mv_rise", t);
    wait_for(1, 1'b0, 50, "tmo_mv_fall", d);
    wait_for(3, 1'b1, 40, "wait_timeout", t);
    chk("tmo_delay", t - d, 16);
    chk("tmo_busy", busy, 0);
    tick();
    chk("tmo_one_cycle", tmo, 0);
    chk("tmo_count", tmo_cnt, 1);
    chk("tmo_no_done", done_cnt - d0, 0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_op_rd", op_rd, 0);
      chk("rst_mv", mv, 0);
      chk("rst_done", done, 0);
      chk("rst_a_addr", a_addr, 0);
      chk("rst_b_addr", b_addr, 0);
      chk("rst_pad", pad, 0);
    end
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_op_rd", op_rd, 0);
    end
    run_full(1'b0, 1'b1);
    repeat (3) tick();
    run_full(1'b1, 1'b0);
    repeat (3) tick();
    reset_mid_issue();
`ifdef MUL_SEQ_TIMEOUT_EN
    repeat (3) tick();
    timeout_test();
`endif
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000ns, expected finish");
    $fatal(1);
  end

endmodule
